// File: rtl/vending_multi_pkg.sv
// Shared types and helpers for the multi-row card vending controller.
package vending_multi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELOADING,
    S_CODE1,
    S_CODE2,
    S_CHECK,
    S_TRANSACT,
    S_VENDING
  } state_t;

  localparam int unsigned DIGIT_MAX = 9;
  localparam int unsigned COLS      = 10;

  // Flat item index d1*10+d2; callers narrow it to their index width.
  function automatic int unsigned item_index(input logic [3:0] d1, input logic [3:0] d2);
    return 32'(d1) * COLS + 32'(d2);
  endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Front-end / dispenser signal bundle for vending_machine_multi.
interface vending_machine_multi_if #(
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COST_W = 4
);
  localparam int unsigned IDX_W = $clog2(ROWS * 10);

  logic              RELOAD;
  logic              CARD_IN;
  logic [3:0]        ITEM_CODE;
  logic              KEY_PRESS;
  logic              CANCEL;
  logic              VALID_TRAN;
  logic              DOOR_OPEN;
  logic              PRICE_WE;
  logic [IDX_W-1:0]  PRICE_ADDR;
  logic [COST_W-1:0] PRICE_DATA;
  logic              VEND;
  logic              INVALID_SEL;
  logic              SOLD_OUT;
  logic [COST_W-1:0] COST;
  logic              FAILED_TRAN;

  modport master (
    output RELOAD, CARD_IN, ITEM_CODE, KEY_PRESS, CANCEL, VALID_TRAN, DOOR_OPEN,
           PRICE_WE, PRICE_ADDR, PRICE_DATA,
    input  VEND, INVALID_SEL, SOLD_OUT, COST, FAILED_TRAN
  );

  modport slave (
    input  RELOAD, CARD_IN, ITEM_CODE, KEY_PRESS, CANCEL, VALID_TRAN, DOOR_OPEN,
           PRICE_WE, PRICE_ADDR, PRICE_DATA,
    output VEND, INVALID_SEL, SOLD_OUT, COST, FAILED_TRAN
  );
endinterface

// File: rtl/vending_store.sv
// Per-item stock and price storage with one combinational read port.
module vending_store #(
  parameter int unsigned NUM_ITEMS = 20,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned STOCK_W   = 4,
  parameter int unsigned COST_W    = 4,
  parameter int unsigned MAX_STOCK = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_reload_all,
  input  logic               i_dec,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_price_we,
  input  logic [IDX_W-1:0]   i_price_addr,
  input  logic [COST_W-1:0]  i_price_data,
  output logic [STOCK_W-1:0] o_stock_c,
  output logic [COST_W-1:0]  o_price_c
);

  logic [STOCK_W-1:0] r_stock [NUM_ITEMS];
  logic [COST_W-1:0]  r_price [NUM_ITEMS];
  logic               w_idx_ok;
  logic               w_addr_ok;

  assign w_idx_ok  = 32'(i_idx) < NUM_ITEMS;
  assign w_addr_ok = 32'(i_price_addr) < NUM_ITEMS;

  // Reload overwrites every entry; decrement saturates at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) r_stock[i] <= '0;
    end else if (i_reload_all) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(MAX_STOCK);
    end else if (i_dec && w_idx_ok && (r_stock[i_idx] != '0)) begin
      r_stock[i_idx] <= r_stock[i_idx] - STOCK_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) r_price[i] <= '0;
    end else if (i_price_we && w_addr_ok) begin
      r_price[i_price_addr] <= i_price_data;
    end
  end

  assign o_stock_c = w_idx_ok ? r_stock[i_idx] : '0;
  assign o_price_c = w_idx_ok ? r_price[i_idx] : '0;

endmodule

// File: rtl/vending_machine_multi.sv
// Card vending controller: two-digit selection, payment wait and dispense sequencing.
module vending_machine_multi
  import vending_multi_pkg::*;
#(
  parameter int unsigned ROWS        = 2,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned MAX_STOCK   = 10,
  parameter int unsigned COST_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 5
) (
  input logic CLK,
  input logic RESET_N,
  vending_machine_multi_if.slave bus
);

  localparam int unsigned NUM_ITEMS = ROWS * COLS;
  localparam int unsigned IDX_W     = $clog2(NUM_ITEMS);
  localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t             r_state, w_next;
  logic [3:0]         r_d1, r_d2, w_d1_nxt, w_d2_nxt;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic               r_door_seen, w_door_nxt;
  logic               r_vend, r_invalid, r_sold_out, r_failed;
  logic [COST_W-1:0]  r_cost, w_cost_nxt;
  logic               w_invalid_nxt, w_sold_nxt, w_failed_nxt;
  logic               w_reload, w_dec, w_price_we, w_timeout, w_code_ok;
  logic [IDX_W-1:0]   w_idx;
  logic [STOCK_W-1:0] w_stock_c;
  logic [COST_W-1:0]  w_price_c;

  assign w_idx      = IDX_W'(item_index(r_d1, r_d2));
  assign w_code_ok  = (32'(r_d1) < ROWS) && (32'(r_d2) <= DIGIT_MAX);
  assign w_timeout  = (r_timer == TMR_LAST);
  assign w_price_we = bus.PRICE_WE && ((r_state == S_IDLE) || (r_state == S_RELOADING));

  vending_store #(
    .NUM_ITEMS (NUM_ITEMS),
    .IDX_W     (IDX_W),
    .STOCK_W   (STOCK_W),
    .COST_W    (COST_W),
    .MAX_STOCK (MAX_STOCK)
  ) u_store (
    .i_clk        (CLK),
    .i_rst_n      (RESET_N),
    .i_reload_all (w_reload),
    .i_dec        (w_dec),
    .i_idx        (w_idx),
    .i_price_we   (w_price_we),
    .i_price_addr (bus.PRICE_ADDR),
    .i_price_data (bus.PRICE_DATA),
    .o_stock_c    (w_stock_c),
    .o_price_c    (w_price_c)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_d1        <= '0;
      r_d2        <= '0;
      r_timer     <= '0;
      r_door_seen <= 1'b0;
      r_vend      <= 1'b0;
      r_invalid   <= 1'b0;
      r_sold_out  <= 1'b0;
      r_failed    <= 1'b0;
      r_cost      <= '0;
    end else begin
      r_state     <= w_next;
      r_d1        <= w_d1_nxt;
      r_d2        <= w_d2_nxt;
      r_timer     <= w_timer_nxt;
      r_door_seen <= w_door_nxt;
      r_vend      <= (w_next == S_VENDING);
      r_invalid   <= w_invalid_nxt;
      r_sold_out  <= w_sold_nxt;
      r_failed    <= w_failed_nxt;
      r_cost      <= w_cost_nxt;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_d1_nxt      = r_d1;
    w_d2_nxt      = r_d2;
    w_door_nxt    = r_door_seen;
    w_invalid_nxt = 1'b0;
    w_sold_nxt    = 1'b0;
    w_failed_nxt  = 1'b0;
    w_reload      = 1'b0;
    w_dec         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.RELOAD)       w_next = S_RELOADING;
        else if (bus.CARD_IN) w_next = S_CODE1;
      end
      S_RELOADING: begin
        w_reload = 1'b1;
        if (!bus.RELOAD) w_next = S_IDLE;
      end
      S_CODE1: begin
        if (bus.KEY_PRESS) begin
          w_d1_nxt = bus.ITEM_CODE;
          w_next   = S_CODE2;
        end else if (bus.CANCEL) begin
          w_next = S_IDLE;
        end else if (w_timeout) begin
          w_next        = S_IDLE;
          w_invalid_nxt = 1'b1;
        end
      end
      S_CODE2: begin
        if (bus.KEY_PRESS) begin
          w_d2_nxt = bus.ITEM_CODE;
          w_next   = S_CHECK;
        end else if (bus.CANCEL) begin
          w_next = S_IDLE;
        end else if (w_timeout) begin
          w_next        = S_IDLE;
          w_invalid_nxt = 1'b1;
        end
      end
      S_CHECK: begin
        // Bad code or unpriced item takes precedence over an empty slot.
        if (!w_code_ok || (w_price_c == '0)) begin
          w_next        = S_IDLE;
          w_invalid_nxt = 1'b1;
        end else if (w_stock_c == '0) begin
          w_next        = S_IDLE;
          w_invalid_nxt = 1'b1;
          w_sold_nxt    = 1'b1;
        end else begin
          w_next = S_TRANSACT;
        end
      end
      S_TRANSACT: begin
        if (bus.VALID_TRAN) begin
          w_next     = S_VENDING;
          w_dec      = 1'b1;
          w_door_nxt = 1'b0;
        end else if (bus.CANCEL) begin
          w_next = S_IDLE;
        end else if (w_timeout) begin
          w_next       = S_IDLE;
          w_failed_nxt = 1'b1;
        end
      end
      S_VENDING: begin
        if (bus.DOOR_OPEN)     w_door_nxt = 1'b1;
        else if (r_door_seen)  w_next     = S_IDLE;
        else if (w_timeout)    w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // An open door pins the timer so a long pickup never times out.
    if ((w_next != r_state) || ((r_state == S_VENDING) && bus.DOOR_OPEN))
      w_timer_nxt = '0;
    else if (r_timer != {TMR_W{1'b1}})
      w_timer_nxt = r_timer + TMR_W'(1);
    else
      w_timer_nxt = r_timer;

    w_cost_nxt = ((w_next == S_TRANSACT) || (w_next == S_VENDING)) ? w_price_c : '0;
  end

  assign bus.VEND        = r_vend;
  assign bus.INVALID_SEL = r_invalid;
  assign bus.SOLD_OUT    = r_sold_out;
  assign bus.COST        = r_cost;
  assign bus.FAILED_TRAN = r_failed;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed self-checking bench for vending_machine_multi (ROWS=2, TIMEOUT_CYC=5).
module tb_vending_machine_multi;
  import vending_multi_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   exp_stock13;

  vending_machine_multi_if #(.ROWS(2), .COST_W(4)) bus ();

  vending_machine_multi #(
    .ROWS(2), .STOCK_W(4), .MAX_STOCK(10), .COST_W(4), .TIMEOUT_CYC(5)
  ) u_dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.RELOAD = 0; bus.CARD_IN = 0; bus.ITEM_CODE = 0; bus.KEY_PRESS = 0;
    bus.CANCEL = 0; bus.VALID_TRAN = 0; bus.DOOR_OPEN = 0; bus.PRICE_WE = 0;
    bus.PRICE_ADDR = 0; bus.PRICE_DATA = 0;
  endtask

  // Card + two keys; returns one cycle after CHECK so the outcome is visible.
  task automatic select_item(input logic [3:0] a, input logic [3:0] b);
    bus.CARD_IN = 1; tick(); bus.CARD_IN = 0;
    bus.KEY_PRESS = 1; bus.ITEM_CODE = a; tick();
    bus.ITEM_CODE = b; tick();
    bus.KEY_PRESS = 0; tick();
  endtask

  task automatic write_price(input logic [4:0] addr, input logic [3:0] val);
    bus.PRICE_WE = 1; bus.PRICE_ADDR = addr; bus.PRICE_DATA = val; tick();
    bus.PRICE_WE = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    checks++;
    if ({bus.VEND, bus.INVALID_SEL, bus.SOLD_OUT, bus.FAILED_TRAN, bus.COST} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0", {bus.VEND, bus.INVALID_SEL, bus.SOLD_OUT, bus.FAILED_TRAN, bus.COST});
    end
    checks++;
    if (u_dut.r_state !== S_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d want %0d", u_dut.r_state, S_IDLE);
    end
  endtask

  task automatic test_basic_vend();
    write_price(5'd13, 4'd4);
    bus.RELOAD = 1; tick(); bus.RELOAD = 0; tick();
    checks++;
    if (u_dut.u_store.r_stock[13] !== 4'd10) begin
      failures++;
      $display("FAIL reload_stock: got %0d want 10", u_dut.u_store.r_stock[13]);
    end
    select_item(4'd1, 4'd3);
    checks++;
    if (bus.COST !== 4'd4 || bus.VEND !== 1'b0) begin
      failures++;
      $display("FAIL transact_cost: got cost=%0d vend=%b want cost=4 vend=0", bus.COST, bus.VEND);
    end
    bus.VALID_TRAN = 1; tick(); bus.VALID_TRAN = 0;
    checks++;
    if (bus.VEND !== 1'b1 || bus.COST !== 4'd4 || u_dut.u_store.r_stock[13] !== 4'd9) begin
      failures++;
      $display("FAIL vending_entry: got vend=%b cost=%0d stock=%0d want 1/4/9",
               bus.VEND, bus.COST, u_dut.u_store.r_stock[13]);
    end
    bus.DOOR_OPEN = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.VEND !== 1'b1) begin
        failures++;
        $display("FAIL door_held_%0d: got vend=%b want 1", i, bus.VEND);
      end
    end
    bus.DOOR_OPEN = 0; tick();
    checks++;
    if (bus.VEND !== 1'b0 || bus.COST !== 4'd0 || u_dut.u_store.r_stock[13] !== 4'd9) begin
      failures++;
      $display("FAIL door_closed: got vend=%b cost=%0d stock=%0d want 0/0/9",
               bus.VEND, bus.COST, u_dut.u_store.r_stock[13]);
    end
    exp_stock13 = 9;
  endtask

  task automatic test_sold_out();
    write_price(5'd5, 4'd3);
    for (int n = 0; n < 10; n++) begin
      select_item(4'd0, 4'd5);
      checks++;
      if (bus.COST !== 4'd3) begin
        failures++;
        $display("FAIL vend05_cost_%0d: got %0d want 3", n, bus.COST);
      end
      bus.VALID_TRAN = 1; tick(); bus.VALID_TRAN = 0;
      bus.DOOR_OPEN = 1; tick(); bus.DOOR_OPEN = 0; tick();
    end
    checks++;
    if (u_dut.u_store.r_stock[5] !== 4'd0) begin
      failures++;
      $display("FAIL stock05_empty: got %0d want 0", u_dut.u_store.r_stock[5]);
    end
    select_item(4'd0, 4'd5);
    checks++;
    if (bus.INVALID_SEL !== 1'b1 || bus.SOLD_OUT !== 1'b1 || bus.COST !== 4'd0) begin
      failures++;
      $display("FAIL sold_out_pulse: got inv=%b sold=%b cost=%0d want 1/1/0",
               bus.INVALID_SEL, bus.SOLD_OUT, bus.COST);
    end
    tick();
    checks++;
    if (bus.INVALID_SEL !== 1'b0 || bus.SOLD_OUT !== 1'b0) begin
      failures++;
      $display("FAIL sold_out_one_cycle: got inv=%b sold=%b want 0/0", bus.INVALID_SEL, bus.SOLD_OUT);
    end
  endtask

  task automatic test_invalid_sel();
    logic [3:0] d1s [3];
    logic [3:0] d2s [3];
    d1s[0] = 4'd2; d2s[0] = 4'd0;
    d1s[1] = 4'd0; d2s[1] = 4'd12;
    d1s[2] = 4'd1; d2s[2] = 4'd9;
    for (int i = 0; i < 3; i++) begin
      select_item(d1s[i], d2s[i]);
      checks++;
      if (bus.INVALID_SEL !== 1'b1 || bus.SOLD_OUT !== 1'b0 || bus.COST !== 4'd0) begin
        failures++;
        $display("FAIL invalid_sel_%0d%0d: got inv=%b sold=%b cost=%0d want 1/0/0",
                 d1s[i], d2s[i], bus.INVALID_SEL, bus.SOLD_OUT, bus.COST);
      end
      tick();
    end
  endtask

  task automatic test_timeouts();
    bus.CARD_IN = 1; tick(); bus.CARD_IN = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.INVALID_SEL !== 1'b0) begin
        failures++;
        $display("FAIL key_wait_%0d: got inv=%b want 0", i, bus.INVALID_SEL);
      end
    end
    tick();
    checks++;
    if (bus.INVALID_SEL !== 1'b1 || u_dut.r_state !== S_IDLE) begin
      failures++;
      $display("FAIL key_timeout: got inv=%b state=%0d want 1/IDLE", bus.INVALID_SEL, u_dut.r_state);
    end
    select_item(4'd1, 4'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.FAILED_TRAN !== 1'b0 || bus.COST !== 4'd4) begin
        failures++;
        $display("FAIL pay_wait_%0d: got failed=%b cost=%0d want 0/4", i, bus.FAILED_TRAN, bus.COST);
      end
    end
    tick();
    checks++;
    if (bus.FAILED_TRAN !== 1'b1 || bus.COST !== 4'd0 || u_dut.u_store.r_stock[13] !== 4'(exp_stock13)) begin
      failures++;
      $display("FAIL pay_timeout: got failed=%b cost=%0d stock=%0d want 1/0/%0d",
               bus.FAILED_TRAN, bus.COST, u_dut.u_store.r_stock[13], exp_stock13);
    end
    tick();
  endtask

  task automatic test_cancel();
    bus.CARD_IN = 1; tick(); bus.CARD_IN = 0;
    bus.KEY_PRESS = 1; bus.ITEM_CODE = 4'd1; tick(); bus.KEY_PRESS = 0;
    bus.CANCEL = 1; tick(); bus.CANCEL = 0;
    checks++;
    if (u_dut.r_state !== S_IDLE || bus.INVALID_SEL !== 1'b0) begin
      failures++;
      $display("FAIL cancel_code2: got state=%0d inv=%b want IDLE/0", u_dut.r_state, bus.INVALID_SEL);
    end
    select_item(4'd1, 4'd3);
    bus.CANCEL = 1; tick(); bus.CANCEL = 0;
    checks++;
    if (u_dut.r_state !== S_IDLE || bus.COST !== 4'd0 || bus.FAILED_TRAN !== 1'b0 || bus.INVALID_SEL !== 1'b0) begin
      failures++;
      $display("FAIL cancel_transact: got state=%0d cost=%0d failed=%b inv=%b want IDLE/0/0/0",
               u_dut.r_state, bus.COST, bus.FAILED_TRAN, bus.INVALID_SEL);
    end
    select_item(4'd1, 4'd3);
    bus.CANCEL = 1; bus.VALID_TRAN = 1; tick(); bus.VALID_TRAN = 0;
    exp_stock13 = exp_stock13 - 1;
    checks++;
    if (bus.VEND !== 1'b1 || u_dut.u_store.r_stock[13] !== 4'(exp_stock13)) begin
      failures++;
      $display("FAIL valid_beats_cancel: got vend=%b stock=%0d want 1/%0d",
               bus.VEND, u_dut.u_store.r_stock[13], exp_stock13);
    end
    // Door never opens: VENDING holds for the full timeout, ignoring CANCEL.
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.CANCEL = 0;
      checks++;
      if (bus.VEND !== 1'b1) begin
        failures++;
        $display("FAIL vend_hold_%0d: got vend=%b want 1", i, bus.VEND);
      end
    end
    tick();
    checks++;
    if (bus.VEND !== 1'b0 || u_dut.r_state !== S_IDLE || u_dut.u_store.r_stock[13] !== 4'(exp_stock13)) begin
      failures++;
      $display("FAIL vend_timeout: got vend=%b state=%0d stock=%0d want 0/IDLE/%0d",
               bus.VEND, u_dut.r_state, u_dut.u_store.r_stock[13], exp_stock13);
    end
  endtask

  task automatic test_async_reset();
    int nonzero;
    select_item(4'd1, 4'd3);
    write_price(5'd13, 4'd7);
    checks++;
    if (u_dut.u_store.r_price[13] !== 4'd4 || bus.COST !== 4'd4) begin
      failures++;
      $display("FAIL price_we_in_transact: got price=%0d cost=%0d want 4/4",
               u_dut.u_store.r_price[13], bus.COST);
    end
    bus.VALID_TRAN = 1; tick(); bus.VALID_TRAN = 0;
    checks++;
    if (bus.VEND !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_vend: got %b want 1", bus.VEND);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus.VEND !== 1'b0 || bus.COST !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_outputs: got vend=%b cost=%0d want 0/0", bus.VEND, bus.COST);
    end
    nonzero = 0;
    for (int i = 0; i < 20; i++)
      if (u_dut.u_store.r_stock[i] !== 4'd0 || u_dut.u_store.r_price[i] !== 4'd0) nonzero++;
    checks++;
    if (nonzero !== 0) begin
      failures++;
      $display("FAIL async_reset_store: got %0d nonzero entries want 0", nonzero);
    end
    tick();
    rst_n = 1;
    tick();
    checks++;
    if (u_dut.r_state !== S_IDLE || bus.VEND !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: got state=%0d vend=%b want IDLE/0", u_dut.r_state, bus.VEND);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_stock13 = 0;
    rst_n = 0;
    test_reset();
    test_basic_vend();
    test_sold_out();
    test_invalid_sel();
    test_timeouts();
    test_cancel();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised successor to the two-digit card vending controller. Generalisations:
- Configurable item rows, stock depth and price width.
- Run-time programmable price table.
- Configurable timeout.
- CANCEL key and a distinct SOLD_OUT indication.

It sits between the keypad/card front-end and the dispenser/door hardware. It is the single owner of per-item stock and price state.

Parameters:
ROWS, 2, valid first digits 0..ROWS-1 (1..10); NUM_ITEMS = ROWS*10, item index = d1*10+d2
STOCK_W, 4, stock counter width per item
MAX_STOCK, 10, value loaded into every item on reload (must fit STOCK_W)
COST_W, 4, price width
TIMEOUT_CYC, 5, cycles a waiting state holds before timing out (>=2)

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
RELOAD  in  1  level; operator reload request
CARD_IN  in  1  card present
ITEM_CODE  in  4  keypad digit, sampled when KEY_PRESS=1
KEY_PRESS  in  1  one-cycle digit strobe
CANCEL  in  1  customer abort
VALID_TRAN  in  1  payment approved
DOOR_OPEN  in  1  dispenser door level
PRICE_WE  in  1  price write strobe
PRICE_ADDR  in  clog2(NUM_ITEMS)  price entry index
PRICE_DATA  in  COST_W  price value; 0 = not for sale
VEND  out  1  dispense enable
INVALID_SEL  out  1  one-cycle pulse: bad or unavailable selection, or key timeout
SOLD_OUT  out  1  one-cycle pulse, coincident with INVALID_SEL, when the cause is stock==0
COST  out  COST_W  price of selected item
FAILED_TRAN  out  1  one-cycle pulse: payment timeout

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - State IDLE; all outputs 0.
  - All stock and price entries 0; timer 0.
  - Reset mid-operation aborts immediately; no stock change.
- All outputs are registered.
- States: IDLE, RELOADING, CODE1, CODE2, CHECK, TRANSACT, VENDING.
- Timer: cleared on every state change, otherwise increments (saturating). "Timeout" = timer==TIMEOUT_CYC-1 with no exit event that cycle, so a waiting state exits after exactly TIMEOUT_CYC cycles.
- IDLE:
  - RELOAD -> RELOADING (priority over CARD_IN).
  - Otherwise CARD_IN -> CODE1.
- RELOADING:
  - Every entry's stock := MAX_STOCK on each cycle in this state.
  - RELOAD low -> IDLE.
- Price writes: PRICE_WE accepted only in IDLE or RELOADING, otherwise ignored. PRICE_ADDR >= NUM_ITEMS is ignored.
- CODE1:
  - KEY_PRESS latches d1 -> CODE2.
  - CANCEL -> IDLE, silent; KEY_PRESS wins over CANCEL.
  - Timeout -> IDLE, pulse INVALID_SEL.
- CODE2: same rules as CODE1; latches d2 -> CHECK.
- CHECK (1 cycle; stock/price read):
  - d1>=ROWS, d2>9 or price==0 -> IDLE + INVALID_SEL.
  - stock==0 -> IDLE + INVALID_SEL + SOLD_OUT.
  - Otherwise -> TRANSACT.
- TRANSACT:
  - COST = price[index].
  - VALID_TRAN -> VENDING (wins over CANCEL).
  - CANCEL -> IDLE, silent.
  - Timeout -> IDLE + FAILED_TRAN.
- VENDING:
  - VEND=1 and COST held throughout.
  - stock[index] decremented exactly once, on entry; never underflows.
  - CANCEL ignored.
  - Door opened then closed -> IDLE.
  - Door held open -> stay indefinitely; timer frozen at 0.
  - Door never opened within TIMEOUT_CYC cycles -> IDLE (stock stays decremented).
- COST=0 in all states except TRANSACT and VENDING.
- Pulses are asserted in the first IDLE cycle after the cause.
- CARD_IN removal is ignored after CODE1 entry.

Decomposition:
- Package vending_multi_pkg: state enum, DIGIT_MAX=9, COLS=10, index function (d1*10+d2 sized to clog2(NUM_ITEMS)).
- Sub-module vending_store: stock and price arrays.
  - One read port: stock+price at index.
  - Price write port.
  - Reload-all and decrement-at-index controls.
  - Asynchronous clear.

Test Plan:
1. Reset; write price[13]=4; reload; CARD_IN, keys 1,3; VALID_TRAN -> COST=4 in TRANSACT; VEND=1; door 1->0 -> IDLE, stock[13]=9.
2. Ten successful vends of item 05, then an eleventh attempt -> CHECK -> INVALID_SEL=1 and SOLD_OUT=1 for one cycle; stock[05]=0.
3. Key 2 as first digit (ROWS=2) -> INVALID_SEL, no SOLD_OUT; keys 0,12 -> INVALID_SEL; item with price 0 -> INVALID_SEL only.
4. CARD_IN, no key for 5 cycles -> IDLE + INVALID_SEL; reach TRANSACT, no VALID_TRAN for 5 cycles -> FAILED_TRAN, stock unchanged.
5. CANCEL in CODE2 and in TRANSACT -> IDLE with no pulses; CANCEL with VALID_TRAN in the same cycle -> VENDING.
6. RESET_N low mid-VENDING -> VEND=0 without a clock edge, all stock and price entries 0; PRICE_WE during TRANSACT has no effect.
